// File: rtl/raymarch_scheduler.sv
// Multithreaded iterative raymarcher: a ring of LOOP slots recirculates rays through one
// unit-box SDF step (SDF_LAT cycles) plus a three-stage update/termination tail.
module raymarch_scheduler #(
    parameter int unsigned SDF_LAT  = 10,
    parameter int unsigned MAX_ITR  = 32,
    parameter int unsigned ITR_W    = 6,
    parameter int unsigned ID_W     = 19,
    parameter logic [26:0] EPSILON  = 27'h1f26666,
    parameter logic [26:0] MAX_DIST = 27'h2180000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ID_W-1:0] in_tag,
    input  logic [26:0]     in_eye_x,
    input  logic [26:0]     in_eye_y,
    input  logic [26:0]     in_eye_z,
    input  logic [26:0]     in_dir_x,
    input  logic [26:0]     in_dir_y,
    input  logic [26:0]     in_dir_z,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ID_W-1:0] out_tag,
    output logic            out_hit,
    output logic [ITR_W-1:0] out_itr,
    output logic [26:0]     out_depth,
    output logic [26:0]     out_point_x,
    output logic [26:0]     out_point_y,
    output logic [26:0]     out_point_z
);

    localparam logic [26:0] FpNegOne = 27'h5fc0000;

    typedef struct packed {
        logic             valid;
        logic             done;
        logic             hit;
        logic [ITR_W-1:0] itr;
        logic [ID_W-1:0]  tag;
        logic [26:0]      depth;
        logic [26:0]      px;
        logic [26:0]      py;
        logic [26:0]      pz;
        logic [26:0]      dx;
        logic [26:0]      dy;
        logic [26:0]      dz;
    } slot_t;

    // Float helpers: exponent 0 is treated as zero, results truncate.
    function automatic logic fp_gt(input logic [26:0] a, input logic [26:0] b);
        logic az;
        logic bz;
        az = (a[25:18] == 8'd0);
        bz = (b[25:18] == 8'd0);
        if (az && bz) return 1'b0;
        if (az) return b[26];
        if (bz) return !a[26];
        if (a[26] != b[26]) return !a[26];
        if (a[26]) return a[25:0] < b[25:0];
        return a[25:0] > b[25:0];
    endfunction

    function automatic logic [26:0] fp_mul(input logic [26:0] a, input logic [26:0] b);
        logic [37:0] prod;
        logic [17:0] man;
        logic        sgn;
        int          ex;
        if (a[25:18] == 8'd0 || b[25:18] == 8'd0) return '0;
        sgn  = a[26] ^ b[26];
        prod = 38'({1'b1, a[17:0]}) * 38'({1'b1, b[17:0]});
        ex   = int'(a[25:18]) + int'(b[25:18]) - 127;
        if (prod[37]) begin
            man = prod[36:19];
            ex  = ex + 1;
        end else begin
            man = prod[35:18];
        end
        if (ex <= 0) return '0;
        if (ex >= 255) return {sgn, 8'hfe, 18'h3ffff};
        return {sgn, ex[7:0], man};
    endfunction

    function automatic logic [26:0] fp_add(input logic [26:0] a, input logic [26:0] b);
        logic [26:0] big;
        logic [26:0] sml;
        logic [21:0] m_big;
        logic [21:0] m_sml;
        logic [22:0] sum;
        int          sh;
        int          ex;
        if (b[25:18] == 8'd0) return (a[25:18] == 8'd0) ? 27'd0 : a;
        if (a[25:18] == 8'd0) return b;
        if (a[25:0] >= b[25:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        sh    = int'(big[25:18]) - int'(sml[25:18]);
        ex    = int'(big[25:18]);
        m_big = {1'b1, big[17:0], 3'b000};
        m_sml = (sh > 21) ? 22'd0 : ({1'b1, sml[17:0], 3'b000} >> sh);
        if (big[26] == sml[26]) begin
            sum = {1'b0, m_big} + {1'b0, m_sml};
            if (sum[22]) begin
                sum = sum >> 1;
                ex  = ex + 1;
            end
        end else begin
            sum = {1'b0, m_big} - {1'b0, m_sml};
            if (sum == 23'd0) return '0;
            for (int i = 0; i < 22; i++) begin
                if (!sum[21]) begin
                    sum = sum << 1;
                    ex  = ex - 1;
                end
            end
        end
        if (ex <= 0) return '0;
        if (ex >= 255) return {big[26], 8'hfe, 18'h3ffff};
        return {big[26], ex[7:0], sum[20:3]};
    endfunction

    // Digit-by-digit root of the mantissa; odd exponents fold one bit into the radicand.
    function automatic logic [26:0] fp_sqrt(input logic [26:0] a);
        logic [37:0] rad;
        logic [21:0] rem;
        logic [21:0] trial;
        logic [18:0] root;
        int          ue;
        if (a[26] || a[25:18] == 8'd0) return '0;
        ue  = int'(a[25:18]) - 127;
        rad = {19'd0, 1'b1, a[17:0]} << 18;
        if (ue[0]) begin
            rad = rad << 1;
            ue  = ue - 1;
        end
        rem  = '0;
        root = '0;
        for (int i = 18; i >= 0; i--) begin
            rem   = {rem[19:0], rad[2*i +: 2]};
            trial = {1'b0, root, 2'b01};
            if (rem >= trial) begin
                rem  = rem - trial;
                root = {root[17:0], 1'b1};
            end else begin
                root = {root[17:0], 1'b0};
            end
        end
        ue = 127 + (ue >>> 1);
        return {1'b0, ue[7:0], root[17:0]};
    endfunction

    function automatic logic [26:0] sdf_box(input logic [26:0] px, input logic [26:0] py,
                                            input logic [26:0] pz);
        logic [26:0] qx, qy, qz, mx, my, mz, len, qmax, inner;
        qx    = fp_add({1'b0, px[25:0]}, FpNegOne);
        qy    = fp_add({1'b0, py[25:0]}, FpNegOne);
        qz    = fp_add({1'b0, pz[25:0]}, FpNegOne);
        mx    = qx[26] ? 27'd0 : qx;
        my    = qy[26] ? 27'd0 : qy;
        mz    = qz[26] ? 27'd0 : qz;
        len   = fp_sqrt(fp_add(fp_add(fp_mul(mx, mx), fp_mul(my, my)), fp_mul(mz, mz)));
        qmax  = fp_gt(qx, qy) ? qx : qy;
        qmax  = fp_gt(qmax, qz) ? qmax : qz;
        inner = fp_gt(qmax, 27'd0) ? 27'd0 : qmax;
        return fp_add(len, inner);
    endfunction

    slot_t       head_q, head_d;
    slot_t       issue;
    slot_t       sdf_slot_q [SDF_LAT];
    slot_t       sdf_slot_d [SDF_LAT];
    logic [26:0] sdf_dist_q [SDF_LAT];
    logic [26:0] sdf_dist_d [SDF_LAT];

    slot_t       a_slot_q, a_slot_d;
    logic        a_hit_q, a_hit_d;
    logic [26:0] a_depth_q, a_depth_d;
    logic [26:0] a_mx_q, a_mx_d, a_my_q, a_my_d, a_mz_q, a_mz_d;

    slot_t       b_slot_q, b_slot_d;
    logic        b_hit_q, b_hit_d;
    logic [26:0] b_depth_q, b_depth_d;
    logic [26:0] b_px_q, b_px_d, b_py_q, b_py_d, b_pz_q, b_pz_d;

    logic [ITR_W-1:0] itr_next;

    assign in_ready    = !head_q.valid || (head_q.done && out_ready);
    assign out_valid   = head_q.valid && head_q.done;
    assign out_tag     = head_q.tag;
    assign out_hit     = head_q.hit;
    assign out_itr     = head_q.itr;
    assign out_depth   = head_q.depth;
    assign out_point_x = head_q.px;
    assign out_point_y = head_q.py;
    assign out_point_z = head_q.pz;

    // Head decision: recirculate, hold a blocked result, or refill a free slot.
    always_comb begin
        issue = '0;
        if (head_q.valid && !(head_q.done && out_ready)) begin
            issue = head_q;
        end else if (in_valid) begin
            issue.valid = 1'b1;
            issue.tag   = in_tag;
            issue.px    = in_eye_x;
            issue.py    = in_eye_y;
            issue.pz    = in_eye_z;
            issue.dx    = in_dir_x;
            issue.dy    = in_dir_y;
            issue.dz    = in_dir_z;
        end
        sdf_slot_d[0] = issue;
        sdf_dist_d[0] = sdf_box(issue.px, issue.py, issue.pz);
        for (int i = 1; i < int'(SDF_LAT); i++) begin
            sdf_slot_d[i] = sdf_slot_q[i-1];
            sdf_dist_d[i] = sdf_dist_q[i-1];
        end
    end

    always_comb begin
        a_slot_d  = sdf_slot_q[SDF_LAT-1];
        a_hit_d   = fp_gt(EPSILON, sdf_dist_q[SDF_LAT-1]);
        a_depth_d = fp_add(sdf_slot_q[SDF_LAT-1].depth, sdf_dist_q[SDF_LAT-1]);
        a_mx_d    = fp_mul(sdf_slot_q[SDF_LAT-1].dx, sdf_dist_q[SDF_LAT-1]);
        a_my_d    = fp_mul(sdf_slot_q[SDF_LAT-1].dy, sdf_dist_q[SDF_LAT-1]);
        a_mz_d    = fp_mul(sdf_slot_q[SDF_LAT-1].dz, sdf_dist_q[SDF_LAT-1]);
    end

    always_comb begin
        b_slot_d  = a_slot_q;
        b_hit_d   = a_hit_q;
        b_depth_d = a_depth_q;
        b_px_d    = fp_add(a_slot_q.px, a_mx_q);
        b_py_d    = fp_add(a_slot_q.py, a_my_q);
        b_pz_d    = fp_add(a_slot_q.pz, a_mz_q);
    end

    // Termination: a hit keeps the pre-step point and depth; done and empty slots pass through.
    always_comb begin
        head_d   = b_slot_q;
        itr_next = b_slot_q.itr + ITR_W'(1);
        if (b_slot_q.valid && !b_slot_q.done) begin
            head_d.itr = itr_next;
            if (b_hit_q) begin
                head_d.done = 1'b1;
                head_d.hit  = 1'b1;
            end else begin
                head_d.depth = b_depth_q;
                head_d.px    = b_px_q;
                head_d.py    = b_py_q;
                head_d.pz    = b_pz_q;
                head_d.done  = fp_gt(b_depth_q, MAX_DIST) || (itr_next == ITR_W'(MAX_ITR));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(SDF_LAT); i++) begin
                sdf_slot_q[i] <= '0;
                sdf_dist_q[i] <= '0;
            end
            a_slot_q  <= '0;
            a_hit_q   <= 1'b0;
            a_depth_q <= '0;
            a_mx_q    <= '0;
            a_my_q    <= '0;
            a_mz_q    <= '0;
            b_slot_q  <= '0;
            b_hit_q   <= 1'b0;
            b_depth_q <= '0;
            b_px_q    <= '0;
            b_py_q    <= '0;
            b_pz_q    <= '0;
            head_q    <= '0;
        end else begin
            sdf_slot_q <= sdf_slot_d;
            sdf_dist_q <= sdf_dist_d;
            a_slot_q   <= a_slot_d;
            a_hit_q    <= a_hit_d;
            a_depth_q  <= a_depth_d;
            a_mx_q     <= a_mx_d;
            a_my_q     <= a_my_d;
            a_mz_q     <= a_mz_d;
            b_slot_q   <= b_slot_d;
            b_hit_q    <= b_hit_d;
            b_depth_q  <= b_depth_d;
            b_px_q     <= b_px_d;
            b_py_q     <= b_py_d;
            b_pz_q     <= b_pz_d;
            head_q     <= head_d;
        end
    end

endmodule

// File: doc/raymarch_scheduler.md
# raymarch_scheduler

Iterative, multithreaded successor to the unrolled raymarcher. A single SDF step datapath (unit box `sdf`, direction scale, point update, depth accumulate) is wrapped in a recirculating ring of slots, so one hardware stage serves up to `MAX_ITR` iterations per ray. Rays enter via a valid/ready handshake with a tag, may retire out of order, and leave with hit flag, iteration count, depth and final point. It sits between `frag_to_world_vector` (which supplies direction) and `distance_to_color`.

## Interface
Parameters:
- `SDF_LAT`, 10, latency in cycles of the instantiated `sdf`; ring length `LOOP = SDF_LAT + 3`
- `MAX_ITR`, 32, maximum SDF evaluations per ray (≥1)
- `ITR_W`, 6, width of iteration count; must hold `MAX_ITR`
- `ID_W`, 19, tag width (640×480 pixel index)
- `EPSILON`, 27'h1f26666, hit threshold (0.2)
- `MAX_DIST`, 27'h2180000, escape depth (128.0)

Ports (all floats are 27-bit codebase format: sign [26], exponent [25:18] bias 127, mantissa [17:0]):
- `clk` in 1 — clock
- `reset` in 1 — synchronous, active-high
- `in_valid` in 1 — new ray offered
- `in_ready` out 1 — ray accepted when `in_valid & in_ready` at posedge
- `in_tag` in ID_W — ray identifier
- `in_eye_x/y/z` in 27 each — ray origin
- `in_dir_x/y/z` in 27 each — unit direction
- `out_valid` out 1 — finished ray at ring head
- `out_ready` in 1 — consumer accepts
- `out_tag` out ID_W, `out_hit` out 1, `out_itr` out ITR_W, `out_depth` out 27, `out_point_x/y/z` out 27 each — result

## Operation
- Ring of `LOOP` slots; each slot holds valid, done, tag, point, dir, depth, itr, hit. The slot at the head is the one presented each cycle; ring advances one slot every cycle unconditionally.
- Head decision (priority order):
  1. head valid & !done: recirculate into step datapath.
  2. head valid & done & `out_ready`: retire; slot freed; new input may fill it the same cycle.
  3. head valid & done & !`out_ready`: slot circulates unchanged.
  4. head empty: filled by input if `in_valid`.
- `in_ready = !head.valid | (head.done & out_ready)`; `out_valid = head.valid & head.done`; output fields driven from head slot. Combinational path `out_ready -> in_ready` is intentional.
- New ray: point = eye, depth = 0, itr = 0, hit = 0, done = 0.
- Step (uses codebase FpAdd/FpMul/FpCompare): dist = sdf(point); itr' = itr+1; hit' = (EPSILON > dist); depth' = depth + dist; point' = point + dir·dist.
- Termination, evaluated on step result:
  - hit': done=1, hit=1, point and depth keep pre-step values.
  - else depth' > MAX_DIST: done=1, hit=0, store depth', point'.
  - else itr' == MAX_ITR: done=1, hit=0, store depth', point'.
  - else: store updated values, done=0.
- Done rays never re-enter the step datapath; their fields are frozen.
- Dir and tag are delay-matched through the step, never modified.

## Timing
- Reset: all slot valid=0 on the cycle after `reset` sampled high; `out_valid`=0, `in_ready`=1, all output data fields 0 while head empty. Reset mid-operation discards all in-flight rays, no retirement.
- One SDF evaluation per ray per `LOOP` cycles. Ray accepted at cycle t returns to head at t + k·`LOOP`; earliest `out_valid` for a ray needing n evaluations is t + n·`LOOP`.
- Throughput: up to `LOOP` rays in flight; at most one accept and one retire per cycle.
- Retirement order follows completion, not acceptance; tag identifies ray.
- `out_*` stable while `out_valid & !out_ready` only for that cycle; the same ray reappears `LOOP` cycles later.

## Test plan
- Hit: eye (0,0,-5.0 = 27'h6050000), dir (0,0,1.0 = 27'h1fc0000), tag 5 -> out_tag 5, hit=1, itr=2, depth=4.0 (27'h2040000), point (0,0,-1.0 = 27'h5fc0000), `out_valid` at accept+2·`LOOP`.
- Escape: eye (0,0,-5.0), dir (0,1.0,0) -> hit=0, depth > 27'h2180000, itr < 32.
- Iteration limit: `MAX_ITR`=1, hit-case ray -> hit=0, itr=1, depth=4.0, point (0,0,-1.0).
- Backpressure: `out_ready`=0, offer `LOOP`+3 rays -> exactly `LOOP` accepted, `in_ready`=0 thereafter; release `out_ready` -> all `LOOP` tags retire once, results identical to unblocked run.
- Mixed out-of-order: alternate hit and escape rays back-to-back -> hit rays retire first, every tag exactly once, none lost or duplicated.
- Reset mid-run: assert `reset` for 1 cycle with ring full -> next cycle `out_valid`=0, `in_ready`=1; no stale tag ever retires.
